// File: rtl/pc_jump_pkg.sv
// Shared encodings for the PC/jump unit: request modes, FSM states and stats counter width.
package pc_jump_pkg;

  localparam logic [2:0] MODE_SEQ  = 3'b000;
  localparam logic [2:0] MODE_BEQZ = 3'b001;
  localparam logic [2:0] MODE_BNEZ = 3'b010;
  localparam logic [2:0] MODE_JABS = 3'b011;
  localparam logic [2:0] MODE_CALL = 3'b100;
  localparam logic [2:0] MODE_RET  = 3'b101;
  localparam logic [2:0] MODE_JREG = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/pc_jump_unit_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// and err_o pulses one cycle after any overflow or underflow.
module ras_stack #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_W      = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] pop_data_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            err_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1'b1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_ptr_s;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             err_q, err_d;

  assign wr_ptr_s   = top_q + PTR_ONE;
  assign pop_data_o = mem_q[top_q];
  assign empty_o    = (cnt_q == {(PTR_W + 1){1'b0}});
  assign full_o     = (cnt_q == CNT_MAX);
  assign err_o      = err_q;

  // Pointer/count next state; the ring wraps naturally because depth is a power of two
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (push_i) begin
      top_d = wr_ptr_s;
      if (full_o) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (pop_i) begin
      if (empty_o) begin
        err_d = 1'b1;
      end else begin
        top_d = top_q - PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // State registers and entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= {PTR_W{1'b0}};
      cnt_q <= {(PTR_W + 1){1'b0}};
      err_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_q[i] <= {PC_W{1'b0}};
      end
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (push_i) begin
        mem_q[wr_ptr_s] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/pc_jump_unit.sv
// Registered next-PC generator with return-address stack and one-cycle redirect squash.
// Optional taken-redirect counter enabled by defining PC_JUMP_STATS_EN.
module pc_jump_unit
  import pc_jump_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [2:0]        jump_mode,
  input  logic [PC_W-1:0]   offset,
  input  logic [DATA_W-1:0] result,
  output logic [PC_W-1:0]   pc,
  output logic              flush,
  output logic [DATA_W-1:0] jump_result,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1'b1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_inc_s;
  logic                flush_q, flush_d;
  logic [DATA_W-1:0]   link_q, link_d;
  logic                taken_s, push_s, pop_s, cond_zero_s;
  logic [PC_W-1:0]     ras_top_s;
  logic                ras_empty_s;

  assign pc_inc_s    = pc_q + PC_ONE;
  assign cond_zero_s = (result == {DATA_W{1'b0}});

  // Next-state decode: stall freezes everything, SQUASH ignores the request
  always_comb begin
    state_d = state_q;
    pc_d    = pc_inc_s;
    flush_d = 1'b0;
    link_d  = link_q;
    taken_s = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (state_q == ST_SQUASH) begin
      state_d = ST_RUN;
    end else if (jump_valid) begin
      case (jump_mode)
        MODE_BEQZ: begin
          if (cond_zero_s) begin
            pc_d    = pc_q + offset;
            taken_s = 1'b1;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        MODE_BNEZ: begin
          if (!cond_zero_s) begin
            pc_d    = pc_q + offset;
            taken_s = 1'b1;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        MODE_JABS: begin
          pc_d    = offset;
          taken_s = 1'b1;
        end
        MODE_CALL: begin
          pc_d    = offset;
          taken_s = 1'b1;
          push_s  = 1'b1;
          link_d  = DATA_W'(pc_inc_s);
        end
        MODE_RET: begin
          // An empty-stack return falls through; the stack flags the underflow
          pop_s = 1'b1;
          if (!ras_empty_s) begin
            pc_d    = ras_top_s;
            taken_s = 1'b1;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        MODE_JREG: begin
          pc_d    = result[PC_W-1:0];
          taken_s = 1'b1;
        end
        MODE_SEQ, MODE_RSVD: begin
          pc_d = pc_inc_s;
        end
        default: begin
          pc_d = pc_inc_s;
        end
      endcase
      if (taken_s) begin
        flush_d = 1'b1;
        state_d = ST_SQUASH;
      end else begin
        flush_d = 1'b0;
      end
    end else begin
      pc_d = pc_inc_s;
    end
  end

  // Main state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= PC_W'(RESET_PC);
      flush_q <= 1'b0;
      link_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      link_q  <= link_d;
    end
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (pc_inc_s),
    .pop_data_o  (ras_top_s),
    .empty_o     (ras_empty_s),
    .full_o      (ras_full),
    .err_o       (ras_err)
  );

`ifdef PC_JUMP_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Taken-redirect counter; taken_s is already suppressed under stall and squash
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (taken_s) begin
      cnt_q <= cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = {CNT_W{1'b0}};
`endif

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign jump_result = link_q;
  assign ras_empty   = ras_empty_s;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Table-driven directed bench for pc_jump_unit (default parameters, RAS_DEPTH=4).
module tb_pc_jump_unit;
  import pc_jump_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, jump_valid;
  logic [2:0]  jump_mode;
  logic [9:0]  offset;
  logic [31:0] result;
  logic [9:0]  pc;
  logic        flush;
  logic [31:0] jump_result;
  logic        ras_empty, ras_full, ras_err;
  logic [15:0] taken_cnt;

  pc_jump_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_valid(jump_valid),
    .jump_mode(jump_mode), .offset(offset), .result(result),
    .pc(pc), .flush(flush), .jump_result(jump_result),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        jv;
    logic [2:0]  md;
    logic [9:0]  off;
    logic [31:0] res;
    logic [9:0]  epc;
    logic        efl;
    logic [31:0] elink;
    logic        eemp;
    logic        efull;
    logic        eerr;
  } vec_t;

  vec_t        tv[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          step_no = 0;
  logic [15:0] exp_cnt = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL step %0d %s: got %h, expected %h", step_no, nm, got, exp);
    end
  endtask

  task automatic add(input logic st, input logic jv, input logic [2:0] md,
                     input logic [9:0] off, input logic [31:0] res,
                     input logic [9:0] epc, input logic efl, input logic [31:0] elink,
                     input logic eemp, input logic efull, input logic eerr);
    vec_t v;
    v.st = st; v.jv = jv; v.md = md; v.off = off; v.res = res;
    v.epc = epc; v.efl = efl; v.elink = elink;
    v.eemp = eemp; v.efull = efull; v.eerr = eerr;
    tv.push_back(v);
  endtask

  task automatic step(input logic rs, input logic st, input logic jv, input logic [2:0] md,
                      input logic [9:0] off, input logic [31:0] res,
                      input logic [9:0] epc, input logic efl, input logic [31:0] elink,
                      input logic eemp, input logic efull, input logic eerr);
    rst = rs; stall = st; jump_valid = jv; jump_mode = md; offset = off; result = res;
    @(posedge clk);
    #1;
    step_no++;
    if (rs) begin
      exp_cnt = 16'h0000;
    end else begin
`ifdef PC_JUMP_STATS_EN
      if (efl) exp_cnt = exp_cnt + 16'h0001;
`endif
    end
    chk("pc", {22'h0, pc}, {22'h0, epc});
    chk("flush", {31'h0, flush}, {31'h0, efl});
    chk("jump_result", jump_result, elink);
    chk("ras_empty", {31'h0, ras_empty}, {31'h0, eemp});
    chk("ras_full", {31'h0, ras_full}, {31'h0, efull});
    chk("ras_err", {31'h0, ras_err}, {31'h0, eerr});
    chk("taken_cnt", {16'h0, taken_cnt}, {16'h0, exp_cnt});
  endtask

  initial begin
    //  st    jv    mode       off      res             pc       fl    link    emp   full  err
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd1,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd2,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd3,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd4,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd5,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_BEQZ, 10'h3FD, 32'd0,          10'd2,   1'b1, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_JABS, 10'd100, 32'd0,          10'd3,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd4,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd5,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_BEQZ, 10'h3FD, 32'd7,          10'd6,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_BNEZ, 10'h3FD, 32'd7,          10'd3,   1'b1, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd4,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_BNEZ, 10'd1,   32'd0,          10'd5,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_BEQZ, 10'd1,   32'd0,          10'd6,   1'b1, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd7,   1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_JABS, 10'd9,   32'd0,          10'd9,   1'b1, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd10,  1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd40,  32'd0,          10'd40,  1'b1, 32'd11,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd99,  32'd0,          10'd41,  1'b0, 32'd11,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd80,  32'd0,          10'd80,  1'b1, 32'd42,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd81,  1'b0, 32'd42,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd42,  1'b1, 32'd42,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd43,  1'b0, 32'd42,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd11,  1'b1, 32'd42,  1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd12,  1'b0, 32'd42,  1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd13,  1'b0, 32'd42,  1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd14,  1'b0, 32'd42,  1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd100, 32'd0,          10'd100, 1'b1, 32'd15,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd101, 1'b0, 32'd15,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd200, 32'd0,          10'd200, 1'b1, 32'd102, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd201, 1'b0, 32'd102, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd300, 32'd0,          10'd300, 1'b1, 32'd202, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd301, 1'b0, 32'd202, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd400, 32'd0,          10'd400, 1'b1, 32'd302, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd401, 1'b0, 32'd302, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, MODE_CALL, 10'd500, 32'd0,          10'd500, 1'b1, 32'd402, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd501, 1'b0, 32'd402, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd402, 1'b1, 32'd402, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd403, 1'b0, 32'd402, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd302, 1'b1, 32'd402, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd303, 1'b0, 32'd402, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd202, 1'b1, 32'd402, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd203, 1'b0, 32'd402, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd102, 1'b1, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd103, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd104, 1'b0, 32'd402, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd105, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_JREG, 10'd0,   32'hABCD_F3FE,  10'd1022,1'b1, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd1023,1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_SEQ,  10'd77,  32'd0,          10'd0,   1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RSVD, 10'd55,  32'd0,          10'd1,   1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, MODE_JABS, 10'd77,  32'd0,          10'd1,   1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_JABS, 10'd300, 32'd0,          10'd300, 1'b1, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd300, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_JABS, 10'd7,   32'd0,          10'd301, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd302, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_BNEZ, 10'h3FF, 32'd1,          10'd301, 1'b1, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, MODE_SEQ,  10'd0,   32'd0,          10'd302, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd302, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, MODE_RET,  10'd0,   32'd0,          10'd303, 1'b0, 32'd402, 1'b1, 1'b0, 1'b1);

    // Reset state
    step(1'b1, 1'b0, 1'b0, MODE_SEQ, 10'd0, 32'd0, 10'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, MODE_SEQ, 10'd0, 32'd0, 10'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    foreach (tv[i]) begin
      step(1'b0, tv[i].st, tv[i].jv, tv[i].md, tv[i].off, tv[i].res,
           tv[i].epc, tv[i].efl, tv[i].elink, tv[i].eemp, tv[i].efull, tv[i].eerr);
    end

    // Pending jreg held off by a three-cycle stall, then released
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, MODE_JREG, 10'd0, 32'h0000_0123, 10'd303, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, MODE_JREG, 10'd0, 32'h0000_0123, 10'h123, 1'b1, 32'd402, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, MODE_SEQ,  10'd0, 32'd0,         10'h124, 1'b0, 32'd402, 1'b1, 1'b0, 1'b0);

    // Three taken and two not-taken branches, then reset in mid-sequence
    step(1'b1, 1'b0, 1'b0, MODE_SEQ,  10'd0, 32'd0, 10'd0,  1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, MODE_BEQZ, 10'd5, 32'd0, 10'd5,  1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, MODE_SEQ,  10'd0, 32'd0, 10'd6,  1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, MODE_BNEZ, 10'd5, 32'd0, 10'd7,  1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, MODE_BEQZ, 10'd5, 32'd1, 10'd8,  1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, MODE_BNEZ, 10'd2, 32'd1, 10'd10, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, MODE_SEQ,  10'd0, 32'd0, 10'd11, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, MODE_BEQZ, 10'd4, 32'd0, 10'd15, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
`ifdef PC_JUMP_STATS_EN
    chk("taken_cnt_total", {16'h0, taken_cnt}, 32'd3);
`else
    chk("taken_cnt_total", {16'h0, taken_cnt}, 32'd0);
`endif
    step(1'b1, 1'b0, 1'b1, MODE_BEQZ, 10'd4, 32'd0, 10'd0,  1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    // Back in RUN right after reset: the jump is taken, not squashed
    step(1'b0, 1'b0, 1'b1, MODE_JABS, 10'd50, 32'd0, 10'd50, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_jump_unit.md
Name: pc_jump_unit

Overview:
- Registered next-PC generator for the single-cycle/short-pipe RISC core.
- Decodes jump/branch/call/return requests, holds the PC register and a parametrised return-address stack (RAS), and produces the link value.
- Issues a one-cycle flush on every taken redirect.
- Sits between the decode/ALU stage (condition result, offset) and instruction fetch (pc).

Parameters:
- PC_W, 10, PC width in instruction-word units.
- DATA_W, 32, width of the ALU result input and the link output.
- RAS_DEPTH, 4, number of RAS entries; a power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freezes all state when high.
- jump_valid  in  1  jump_mode/offset/result are valid this cycle.
- jump_mode  in  3  000 seq, 001 beqz, 010 bnez, 011 jabs, 100 call, 101 ret, 110 jreg, 111 reserved (treated as seq).
- offset  in  PC_W  signed branch offset (beqz/bnez), or absolute target (jabs/call).
- result  in  DATA_W  ALU result: condition for branches, target for jreg (low PC_W bits).
- pc  out  PC_W  current PC (registered).
- flush  out  1  one-cycle pulse; the PC was redirected this cycle.
- jump_result  out  DATA_W  link value, zero-extended (PC+1); registered, updated only on call.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_err  out  1  one-cycle pulse on RAS overflow or underflow.
- taken_cnt  out  16  taken-redirect counter (optional feature).

Behaviour:
- Reset values:
  - pc=RESET_PC, flush=0, jump_result=0, ras_err=0, taken_cnt=0.
  - RAS count=0, so ras_empty=1 and ras_full=0.
  - FSM=RUN.
- Priority: rst > stall > normal operation.
- While stall is high, every register holds its value, flush and ras_err are forced to 0, and inputs are ignored.
- FSM states:
  - RUN: decode the request.
  - SQUASH: entered for exactly one non-stalled cycle after a taken redirect. jump_valid is ignored and the PC advances by +1. Returns to RUN.
  - A stall during SQUASH holds the FSM in SQUASH.
- In RUN, next PC (all arithmetic modulo 2^PC_W; wrap-around is legal and silent):
  - No jump_valid, seq, or reserved mode: pc+1.
  - beqz: pc+offset if result==0, else pc+1.
  - bnez: pc+offset if result!=0, else pc+1.
  - jabs: offset.
  - call: offset; push pc+1; jump_result <= pc+1.
  - ret: popped entry if RAS non-empty. If empty, fall through to pc+1 with ras_err=1; not counted as taken.
  - jreg: result[PC_W-1:0].
- Taken redirect: any case whose next PC is not the pc+1 fall-through.
  - A branch with offset==1 is still taken.
  - A taken redirect sets flush=1 in the same registered cycle that pc takes the target, and moves the FSM to SQUASH.
- Latency: one clock from request to pc/flush update.
- RAS:
  - Circular buffer with top pointer and count.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH and ras_err pulses.
  - A call never stalls.

Optional Feature:
- Macro: PC_JUMP_STATS_EN.
- Defined: taken_cnt increments by 1 on each taken redirect and wraps at 16'hFFFF→0. It holds under stall and clears on rst.
- Undefined: no counter logic is built; taken_cnt is tied to 0.
- The port exists in both builds.

Decomposition:
- Package pc_jump_pkg holds:
  - jump_mode encodings (MODE_SEQ … MODE_JREG) as localparams;
  - FSM state encodings (ST_RUN, ST_SQUASH);
  - the counter width of 16.
- Sub-module ras_stack (RAS_DEPTH, PC_W) provides push/pop/data/empty/full/err. Everything else stays in pc_jump_unit.

Test Plan:
- Reset, then 3 idle cycles → pc=0,1,2,3; flush=0; ras_empty=1.
- At pc=5: beqz offset=-3 (10'h3FD), result=0 → pc=2 next cycle with flush=1. The following cycle's jump_valid (jabs 100) is squashed → pc=3. Repeat with result=7 → pc=6, flush=0.
- Nested calls (RAS_DEPTH=4):
  - call 40 at pc=10 → pc=40, jump_result=11.
  - call 80 at pc=41 (issued after the squash cycle) → pc=80.
  - ret → pc=42; ret → pc=11; ras_empty=1.
  - A third ret → pc+1 with ras_err=1.
- Five consecutive calls (each after its squash cycle) → ras_full=1 and ras_err pulse on the fifth. Five rets then return only the 4 newest links, and the 5th ret underflows.
- Wrap and stall: pc=1023 seq → pc=0. Hold stall high 3 cycles during a pending jreg with result=32'h0000_0123 → pc frozen. Release → pc=10'h123, flush=1.
- PC_JUMP_STATS_EN: 3 taken branches and 2 not-taken → taken_cnt=3. Assert rst mid-sequence → taken_cnt=0, pc=RESET_PC, FSM=RUN.
